// File: rtl/picmicro_pkg.sv
// Shared constants and types for the PIC-style program-counter return stack.
// Latency: none (definitions only).
// Backpressure: none; the stack never stalls its caller.
package picmicro_pkg;

  localparam int PC_WIDTH            = 13;
  localparam int STACK_DEPTH_DEFAULT = 8;

  // Policy applied when a push arrives while every entry is occupied.
  typedef enum logic {
    STACK_SATURATE,
    STACK_WRAP
  } stack_mode_t;

endpackage

// File: rtl/picmicro_param_hw_stack.sv
// Parameterised hardware return-address stack (circular buffer) with sticky ovf/unf flags.
// Latency: push/pop take effect at the next rising edge; top_data is combinational from state.
// Backpressure: none; a push to a full stack wraps or is dropped, and a pop from empty is ignored.
module picmicro_param_hw_stack
  import picmicro_pkg::*;
#(
  parameter int          WIDTH = PC_WIDTH,
  parameter int          DEPTH = STACK_DEPTH_DEFAULT,
  parameter stack_mode_t MODE  = STACK_WRAP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_en,
  input  logic                       pop_en,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       flag_clr,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [PW-1:0]    w_wp_inc;
  logic [PW-1:0]    w_top_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_wp_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Pointer neighbours; explicit wrap because DEPTH need not be a power of two.
  always_comb begin
    w_wp_inc  = (r_wp == LAST_IDX) ? '0 : r_wp + PW'(1);
    w_top_idx = (r_wp == '0) ? LAST_IDX : r_wp - PW'(1);
  end

  // Decode push/pop into a storage write, pointer/count update and flag events.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_wp;
    w_wp_nxt    = r_wp;
    w_count_nxt = r_count;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;

    if (push_en && pop_en && !w_empty) begin
      // Return-then-call in one cycle: replace the top in place.
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (push_en) begin
      // Also covers push+pop on an empty stack, which is a plain push.
      if (!w_full) begin
        w_wr_en     = 1'b1;
        w_wp_nxt    = w_wp_inc;
        w_count_nxt = r_count + CW'(1);
      end else begin
        w_set_ovf = 1'b1;
        if (MODE == STACK_WRAP) begin
          // wp already points at the oldest entry when full.
          w_wr_en  = 1'b1;
          w_wp_nxt = w_wp_inc;
        end
      end
    end else if (pop_en) begin
      if (!w_empty) begin
        w_wp_nxt    = w_top_idx;
        w_count_nxt = r_count - CW'(1);
      end else begin
        w_set_unf = 1'b1;
      end
    end
  end

  // State update; a flag-setting event outranks flag_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= push_data;
      end
      r_wp    <= w_wp_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_set_ovf | (r_ovf & ~flag_clr);
      r_unf   <= w_set_unf | (r_unf & ~flag_clr);
    end
  end

  assign top_data = w_empty ? '0 : r_mem[w_top_idx];
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

endmodule

// File: tb/tb_picmicro_param_hw_stack.sv
// Bench for picmicro_param_hw_stack: one wrap and one saturate instance driven in lockstep.
// Expected values come from a queue-based stack model plus directed constants.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_picmicro_param_hw_stack;
  import picmicro_pkg::*;

  localparam int W = 13;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         push_en = 1'b0;
  logic         pop_en = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         flag_clr = 1'b0;

  logic [W-1:0] w_top, s_top;
  logic [3:0]   w_cnt, s_cnt;
  logic         w_emp, s_emp, w_ful, s_ful, w_ovf, s_ovf, w_unf, s_unf;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: queue back is the top of stack.
  logic [W-1:0] mq_w[$];
  logic [W-1:0] mq_s[$];
  bit mov_w, mun_w, mov_s, mun_s;

  always #5 clk = ~clk;

  picmicro_param_hw_stack #(.WIDTH(W), .DEPTH(D), .MODE(STACK_WRAP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .push_en(push_en), .pop_en(pop_en),
    .push_data(push_data), .flag_clr(flag_clr), .top_data(w_top), .count(w_cnt),
    .empty(w_emp), .full(w_ful), .ovf(w_ovf), .unf(w_unf));

  picmicro_param_hw_stack #(.WIDTH(W), .DEPTH(D), .MODE(STACK_SATURATE)) u_sat (
    .clk(clk), .rst_n(rst_n), .push_en(push_en), .pop_en(pop_en),
    .push_data(push_data), .flag_clr(flag_clr), .top_data(s_top), .count(s_cnt),
    .empty(s_emp), .full(s_ful), .ovf(s_ovf), .unf(s_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl(input bit wrap, input bit p, input bit q, input logic [W-1:0] d,
                     input bit c, inout logic [W-1:0] st[$], inout bit ov, inout bit un);
    bit so = 0;
    bit su = 0;
    if (p && q && st.size() > 0) begin
      st[st.size()-1] = d;
    end else if (p) begin
      if (st.size() < D) st.push_back(d);
      else begin
        so = 1;
        if (wrap) begin
          void'(st.pop_front());
          st.push_back(d);
        end
      end
    end else if (q) begin
      if (st.size() > 0) void'(st.pop_back());
      else su = 1;
    end
    ov = so | (ov & !c);
    un = su | (un & !c);
  endtask

  function automatic logic [W-1:0] mtop(input logic [W-1:0] st[$]);
    return (st.size() == 0) ? '0 : st[st.size()-1];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_w_cnt"}, 32'(w_cnt), 32'(mq_w.size()));
    chk({tag, "_w_top"}, 32'(w_top), 32'(mtop(mq_w)));
    chk({tag, "_w_emp"}, 32'(w_emp), 32'(mq_w.size() == 0));
    chk({tag, "_w_ful"}, 32'(w_ful), 32'(mq_w.size() == D));
    chk({tag, "_w_ovf"}, 32'(w_ovf), 32'(mov_w));
    chk({tag, "_w_unf"}, 32'(w_unf), 32'(mun_w));
    chk({tag, "_s_cnt"}, 32'(s_cnt), 32'(mq_s.size()));
    chk({tag, "_s_top"}, 32'(s_top), 32'(mtop(mq_s)));
    chk({tag, "_s_emp"}, 32'(s_emp), 32'(mq_s.size() == 0));
    chk({tag, "_s_ful"}, 32'(s_ful), 32'(mq_s.size() == D));
    chk({tag, "_s_ovf"}, 32'(s_ovf), 32'(mov_s));
    chk({tag, "_s_unf"}, 32'(s_unf), 32'(mun_s));
  endtask

  // One clock of stimulus: drive, take the edge, advance the model, then check.
  task automatic step(input string tag, input bit p, input bit q,
                      input logic [W-1:0] d, input bit c);
    push_en = p; pop_en = q; push_data = d; flag_clr = c;
    @(posedge clk);
    mdl(1'b1, p, q, d, c, mq_w, mov_w, mun_w);
    mdl(1'b0, p, q, d, c, mq_s, mov_s, mun_s);
    #1;
    push_en = 1'b0; pop_en = 1'b0; flag_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq_w.delete(); mq_s.delete();
    mov_w = 0; mun_w = 0; mov_s = 0; mun_s = 0;
  endtask

  // Assert reset between edges, check immediately, release on the next falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    chk({tag, "_w_cnt0"}, 32'(w_cnt), 32'd0);
    chk({tag, "_w_top0"}, 32'(w_top), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state before any clock edge.
    #2;
    model_reset();
    check_all("rst");
    chk("rst_emp", 32'(w_emp), 32'd1);
    chk("rst_ful", 32'(s_ful), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic push/pop.
    step("p21", 1, 0, 13'h0021, 0);
    step("p02", 1, 0, 13'h0002, 0);
    chk("basic_cnt2", 32'(w_cnt), 32'd2);
    chk("basic_top2", 32'(w_top), 32'h0002);
    step("pop1", 0, 1, '0, 0);
    chk("basic_cnt1", 32'(w_cnt), 32'd1);
    chk("basic_top21", 32'(w_top), 32'h0021);
    step("pop2", 0, 1, '0, 0);
    chk("basic_top0", 32'(s_top), 32'h0);

    // Nine pushes into an 8-deep stack.
    for (int i = 0; i < 9; i++) step("fill", 1, 0, W'(13'h100 + i), 0);
    chk("wrap_cnt8", 32'(w_cnt), 32'd8);
    chk("wrap_ovf", 32'(w_ovf), 32'd1);
    chk("wrap_top108", 32'(w_top), 32'h108);
    chk("sat_cnt8", 32'(s_cnt), 32'd8);
    chk("sat_ovf", 32'(s_ovf), 32'd1);
    chk("sat_top107", 32'(s_top), 32'h107);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_drain_top", 32'(w_top), 32'(13'h108 - i));
      step("drain", 0, 1, '0, 0);
    end
    chk("sat_drained_top", 32'(s_top), 32'h0);
    chk("wrap_no_unf_yet", 32'(w_unf), 32'd0);
    step("under", 0, 1, '0, 0);
    chk("wrap_unf", 32'(w_unf), 32'd1);
    chk("sat_unf", 32'(s_unf), 32'd1);
    step("clr", 0, 0, '0, 1);

    // Simultaneous push and pop.
    step("s20", 1, 0, 13'h0020, 0);
    step("s21", 1, 0, 13'h0021, 0);
    step("s22", 1, 0, 13'h0022, 0);
    step("swap", 1, 1, 13'h0555, 0);
    chk("swap_cnt3", 32'(w_cnt), 32'd3);
    chk("swap_top", 32'(w_top), 32'h0555);
    chk("swap_ovf", 32'(w_ovf), 32'd0);
    chk("swap_unf", 32'(w_unf), 32'd0);
    for (int i = 0; i < 3; i++) step("empty_it", 0, 1, '0, 0);
    step("swap_empty", 1, 1, 13'h0555, 0);
    chk("swapE_cnt1", 32'(s_cnt), 32'd1);
    chk("swapE_top", 32'(s_top), 32'h0555);
    chk("swapE_unf", 32'(s_unf), 32'd0);

    // flag_clr racing an overflowing push.
    for (int i = 0; i < 8; i++) step("ovfill", 1, 0, W'(13'h300 + i), 0);
    chk("ov_pre", 32'(w_ovf), 32'd1);
    step("ov_race", 1, 0, 13'h0777, 1);
    chk("ov_race_w", 32'(w_ovf), 32'd1);
    chk("ov_race_s", 32'(s_ovf), 32'd1);
    step("ov_clr", 0, 0, '0, 1);
    chk("ov_clr_w", 32'(w_ovf), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           W'($urandom_range(0, 8191)), $urandom_range(0, 99) < 10);
    end

    // Mid-cycle reset with five entries held.
    do_reset("rst2");
    for (int i = 0; i < 5; i++) step("five", 1, 0, W'(13'h040 + i), 0);
    chk("five_cnt", 32'(w_cnt), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_cnt", 32'(w_cnt), 32'd0);
    chk("mid_emp", 32'(w_emp), 32'd1);
    chk("mid_top", 32'(w_top), 32'd0);
    check_all("mid");
    @(negedge clk);
    rst_n = 1'b1;
    step("post", 1, 0, 13'h000A, 0);
    chk("post_cnt", 32'(w_cnt), 32'd1);
    chk("post_top", 32'(w_top), 32'h000A);
    chk("post_s_top", 32'(s_top), 32'h000A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/picmicro_param_hw_stack.md
PICMICRO_PARAM_HW_STACK -- requirements
Module: picmicro_param_hw_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, return-address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries (legal range 2..64, not necessarily a power of two).
REQ-003 The block SHALL have parameter MODE, default STACK_WRAP, full-stack policy (STACK_WRAP or STACK_SATURATE).
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port push_en  input  1  push push_data this cycle (CALL or interrupt entry).
REQ-007 The block SHALL have port pop_en  input  1  pop the top entry this cycle (RETURN, RETLW or RETFIE).
REQ-008 The block SHALL have port push_data  input  WIDTH  address to push.
REQ-009 The block SHALL have port flag_clr  input  1  clear the sticky ovf and unf flags.
REQ-010 The block SHALL have port top_data  output  WIDTH  current top entry, combinational from state.
REQ-011 The block SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 The block SHALL have ports empty and full  output  1 each  count==0 and count==DEPTH respectively.
REQ-013 The block SHALL have ports ovf and unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries with write pointer wp (0..DEPTH-1) and count; top index = (wp-1) mod DEPTH.
REQ-015 top_data SHALL equal the entry at top index when count>0, and 0 when count==0.
REQ-016 A push with count<DEPTH SHALL write push_data at wp, advance wp (DEPTH-1 wraps to 0) and increment count; top_data shows the new value the next cycle.
REQ-017 A push with count==DEPTH in STACK_WRAP mode SHALL overwrite the oldest entry, advance wp, hold count at DEPTH and set ovf.
REQ-018 A push with count==DEPTH in STACK_SATURATE mode SHALL be discarded (storage, wp and count unchanged) and SHALL set ovf.
REQ-019 A pop with count>0 SHALL retreat wp by one (0 wraps to DEPTH-1) and decrement count; stored data is not cleared.
REQ-020 A pop with count==0 SHALL leave wp and count unchanged, keep top_data at 0 and set unf, in both modes.
REQ-021 Simultaneous push and pop with count>0 SHALL overwrite the entry at top index with push_data, leave wp and count unchanged and set no flag.
REQ-022 Simultaneous push and pop with count==0 SHALL act as a plain push and SHALL NOT set unf.
REQ-023 flag_clr SHALL clear ovf and unf at the next edge, but a flag-setting event in the same cycle SHALL win and leave that flag set.
REQ-024 The outputs count, empty and full SHALL be registered-state derived with no combinational path from push_en or pop_en.

Reset
REQ-025 While rst_n is low, wp, count, ovf and unf SHALL be 0, giving top_data=0, empty=1 and full=0 immediately without waiting for a clock.
REQ-026 Storage entries SHALL be reset to 0.
REQ-027 Reset asserted mid-operation SHALL discard all contents, and the first edge after release SHALL behave as from an empty stack.

Structure
REQ-028 Package picmicro_pkg SHALL hold PC_WIDTH=13, STACK_DEPTH_DEFAULT=8 and enum stack_mode_t {STACK_SATURATE, STACK_WRAP}.
REQ-029 The block SHALL be a single module with no sub-modules, storage being a register array; the core's program-counter unit SHALL instantiate it in place of its fixed stack.

Verification
REQ-030 The bench SHALL cover: reset, push 0x0021 then push 0x0002 -> count=2, top_data=0x0002; pop -> count=1, top_data=0x0021; pop -> count=0, top_data=0.
REQ-031 The bench SHALL cover: STACK_WRAP with DEPTH=8, push 0x100..0x108 (9 pushes) -> count=8, ovf=1, top_data=0x108; 8 pops read 0x108 down to 0x101; a further pop -> unf=1.
REQ-032 The bench SHALL cover: STACK_SATURATE with DEPTH=8, push 0x100..0x108 -> count=8, ovf=1, top_data=0x107, and 8 pops end at top_data=0.
REQ-033 The bench SHALL cover: count=3 with top 0x0022, push_en and pop_en together with push_data 0x0555 -> count=3, top_data=0x0555, ovf=unf=0; the same on empty -> count=1, top_data=0x0555, unf=0.
REQ-034 The bench SHALL cover: ovf=1, flag_clr held together with an overflowing push -> ovf stays 1; flag_clr alone next cycle -> ovf=0.
REQ-035 The bench SHALL cover: rst_n dropped between clock edges with count=5 -> count=0, empty=1 and top_data=0 before the next edge; push 0x0A after release -> count=1, top_data=0x0A.
